plot_arbiter: RTL and testbench

PLOT_ARBITER -- requirements
Module: plot_arbiter

---
 rtl/plot_arbiter.sv | 117 +++++++++++
 tb/tb_plot_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/plot_arbiter.sv
// Arbitrates several pixel sources onto a single registered VGA plot port.
// Ownership is burst-based, with a fixed-priority or round-robin winner search.
module plot_arbiter #(
  parameter int NUM_CH    = 3,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int C_W       = 3,
  parameter int RR_MODE   = 0,
  parameter int MAX_BURST = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     req,
  input  logic [NUM_CH*X_W-1:0] req_x,
  input  logic [NUM_CH*Y_W-1:0] req_y,
  input  logic [NUM_CH*C_W-1:0] req_colour,
  output logic [NUM_CH-1:0]     gnt,
  output logic [X_W-1:0]        x_out,
  output logic [Y_W-1:0]        y_out,
  output logic [C_W-1:0]        colour_out,
  output logic                  plot,
  output logic [2:0]            owner,
  output logic                  busy
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t            state;
  logic [7:0]        burst_cnt;
  logic [7:0]        cnt_next;
  logic [2:0]        last_owner;
  logic [2:0]        winner;
  logic [NUM_CH-1:0] owner_hot;
  logic [NUM_CH-1:0] req_rot;
  logic [X_W-1:0]    sel_x;
  logic [Y_W-1:0]    sel_y;
  logic [C_W-1:0]    sel_c;
  logic              owner_req;
  logic              other_req;
  logic              xfer;
  int                start;

  always_comb begin
    owner_hot = '0;
    sel_x     = '0;
    sel_y     = '0;
    sel_c     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (owner == 3'(i)) begin
        owner_hot[i] = 1'b1;
        sel_x        = req_x[i*X_W +: X_W];
        sel_y        = req_y[i*Y_W +: Y_W];
        sel_c        = req_colour[i*C_W +: C_W];
      end
    end
  end

  assign owner_req = |(req & owner_hot);
  assign other_req = |(req & ~owner_hot);
  assign xfer      = (state == OWNED) && owner_req;
  assign gnt       = (state == OWNED) ? (req & owner_hot) : '0;
  assign cnt_next  = (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;

  // Rotate the request vector so the search always begins at bit 0; fixed
  // priority is simply a rotation of zero.
  always_comb begin
    start   = (RR_MODE != 0) ? (int'(last_owner) + 1) % NUM_CH : 0;
    req_rot = NUM_CH'({req, req} >> start);
    winner  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_rot[k]) winner = 3'((start + k) % NUM_CH);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= '0;
      busy       <= 1'b0;
      burst_cnt  <= '0;
      last_owner <= 3'(NUM_CH - 1);
      plot       <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
    end else begin
      plot <= xfer;
      if (xfer) begin
        x_out      <= sel_x;
        y_out      <= sel_y;
        colour_out <= sel_c;
      end
      case (state)
        IDLE: begin
          if (|req) begin
            state      <= OWNED;
            busy       <= 1'b1;
            owner      <= winner;
            last_owner <= winner;
            burst_cnt  <= '0;
          end
        end
        OWNED: begin
          if (xfer) burst_cnt <= cnt_next;
          // The yield check uses the post-transfer count so a burst of
          // MAX_BURST transfers ends exactly on its last transfer.
          if (!owner_req || (cnt_next >= 8'(MAX_BURST) && other_req)) begin
            state <= IDLE;
            busy  <= 1'b0;
            owner <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench: a fixed-priority instance and a round-robin instance
// (MAX_BURST=2) share the same request and pixel inputs.
module tb_plot_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_colour;

  logic [2:0] gnt_a, owner_a, gnt_b, owner_b;
  logic [7:0] x_a, x_b;
  logic [6:0] y_a, y_b;
  logic [2:0] c_a, c_b;
  logic       plot_a, busy_a, plot_b, busy_b;

  int tests_run = 0;
  int failures  = 0;
  int gaps;
  int exp_rr [12] = '{0, 1, 1, 0, 2, 2, 0, 4, 4, 0, 1, 1};

  plot_arbiter #(.NUM_CH(3), .RR_MODE(0), .MAX_BURST(16)) dut_fixed (
    .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .gnt(gnt_a), .x_out(x_a), .y_out(y_a),
    .colour_out(c_a), .plot(plot_a), .owner(owner_a), .busy(busy_a)
  );

  plot_arbiter #(.NUM_CH(3), .RR_MODE(1), .MAX_BURST(2)) dut_rr (
    .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .gnt(gnt_b), .x_out(x_b), .y_out(y_b),
    .colour_out(c_b), .plot(plot_b), .owner(owner_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Inputs change on the falling edge; checks follow 1 time unit later.
  task automatic applyStimulus(input logic [2:0] r);
    @(negedge clk);
    req = r;
    #1;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b0;
    req = 3'b000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst        = 1'b0;
    req        = 3'b000;
    req_x      = {8'd77, 8'd33, 8'd10};
    req_y      = {7'd99, 7'd44, 7'd20};
    req_colour = {3'd6, 3'd3, 3'd5};

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_gnt",   32'(gnt_a),   0);
    checkOutput("reset_plot",  32'(plot_a),  0);
    checkOutput("reset_owner", 32'(owner_a), 0);
    checkOutput("reset_busy",  32'(busy_a),  0);
    checkOutput("reset_x",     32'(x_a),     0);
    rst = 1'b1;

    // Single transfer from channel 0: plot one clock after the grant cycle
    applyStimulus(3'b001);
    checkOutput("lat_idle_gnt", 32'(gnt_a), 0);
    applyStimulus(3'b001);
    checkOutput("lat_gnt",      32'(gnt_a),  1);
    checkOutput("lat_plot_pre", 32'(plot_a), 0);
    applyStimulus(3'b000);
    checkOutput("lat_plot",   32'(plot_a), 1);
    checkOutput("lat_x",      32'(x_a),    10);
    checkOutput("lat_y",      32'(y_a),    20);
    checkOutput("lat_colour", 32'(c_a),    5);
    applyStimulus(3'b000);
    checkOutput("lat_plot_low", 32'(plot_a), 0);
    checkOutput("lat_busy_low", 32'(busy_a), 0);
    checkOutput("lat_x_hold",   32'(x_a),    10);

    // Fixed priority with channels 1 and 2 requesting
    applyStimulus(3'b110);
    checkOutput("fp_idle_gnt", 32'(gnt_a), 0);
    applyStimulus(3'b110);
    checkOutput("fp_gnt1",   32'(gnt_a),   2);
    checkOutput("fp_owner1", 32'(owner_a), 1);
    applyStimulus(3'b110);
    checkOutput("fp_plot1", 32'(plot_a), 1);
    checkOutput("fp_x1",    32'(x_a),    33);
    checkOutput("fp_hold1", 32'(gnt_a),  2);
    applyStimulus(3'b100);
    checkOutput("fp_drop_gnt", 32'(gnt_a), 0);
    applyStimulus(3'b100);
    checkOutput("fp_gap_busy", 32'(busy_a), 0);
    checkOutput("fp_gap_gnt",  32'(gnt_a),  0);
    applyStimulus(3'b100);
    checkOutput("fp_gnt2",   32'(gnt_a),   4);
    checkOutput("fp_owner2", 32'(owner_a), 2);
    applyStimulus(3'b000);
    checkOutput("fp_plot2", 32'(plot_a), 1);
    checkOutput("fp_x2",    32'(x_a),    77);
    applyStimulus(3'b000);

    // Long uncontended burst well past MAX_BURST and past counter saturation
    applyStimulus(3'b001);
    gaps = 0;
    for (int i = 0; i < 260; i++) begin
      applyStimulus(3'b001);
      if (gnt_a !== 3'b001 || busy_a !== 1'b1) gaps++;
    end
    checkOutput("burst_gaps", 32'(gaps),   0);
    checkOutput("burst_plot", 32'(plot_a), 1);
    applyStimulus(3'b011);
    checkOutput("burst_nonowner", 32'(gnt_a), 1);
    applyStimulus(3'b011);
    checkOutput("burst_yield",     32'(busy_a), 0);
    checkOutput("burst_yield_gnt", 32'(gnt_a),  0);
    applyStimulus(3'b000);
    applyStimulus(3'b000);

    // Round-robin rotation with every channel requesting
    resetDut();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(3'b111);
      checkOutput($sformatf("rr_gnt_%0d", i), 32'(gnt_b), 32'(exp_rr[i]));
    end

    // Reset in the middle of a channel 1 burst
    resetDut();
    applyStimulus(3'b010);
    checkOutput("mid_idle_gnt", 32'(gnt_b), 0);
    applyStimulus(3'b010);
    checkOutput("mid_gnt1", 32'(gnt_b), 2);
    applyStimulus(3'b010);
    checkOutput("mid_plot1", 32'(plot_b), 1);
    checkOutput("mid_x1",    32'(x_b),    33);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req = 3'b011;
    #1;
    checkOutput("mid_rst_gnt",    32'(gnt_b),   0);
    checkOutput("mid_rst_plot",   32'(plot_b),  0);
    checkOutput("mid_rst_owner",  32'(owner_b), 0);
    checkOutput("mid_rst_busy",   32'(busy_b),  0);
    checkOutput("mid_rst_x",      32'(x_b),     0);
    checkOutput("mid_rst_y",      32'(y_b),     0);
    checkOutput("mid_rst_colour", 32'(c_b),     0);
    applyStimulus(3'b011);
    checkOutput("mid_tie_owner", 32'(owner_b), 0);
    checkOutput("mid_tie_gnt",   32'(gnt_b),   1);
    applyStimulus(3'b000);
    applyStimulus(3'b000);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
